// File: rtl/p_hardisc.sv
// Shared types and constants for the hardisc EX-stage divider.
package p_hardisc;

    typedef logic [1:0] f_part;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state;

    localparam f_part DIV_F_DIV  = 2'b00;
    localparam f_part DIV_F_DIVU = 2'b01;
    localparam f_part DIV_F_REM  = 2'b10;
    localparam f_part DIV_F_REMU = 2'b11;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on a {remainder, quotient} pair.
module div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;

    always_comb begin
        shifted = {rem_i, quo_i[31]};
        diff    = shifted - {1'b0, divisor_i};
        // A set top bit means the shifted remainder already exceeds any 32-bit divisor.
        ge      = shifted[32] | ~diff[32];
        rem_o   = ge ? diff[31:0] : shifted[31:0];
        quo_o   = {quo_i[30:0], ge};
    end

endmodule

// File: rtl/ex_divider.sv
// Iterative DIV/DIVU/REM/REMU unit in EX; stalls the front end until the result
// is taken by the EX/MA register.
module ex_divider
    import p_hardisc::*;
#(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_start_i,
    input  logic        s_flush_i,
    input  logic [1:0]  s_f_i,
    input  logic [31:0] s_operand1_i,
    input  logic [31:0] s_operand2_i,
    input  logic [3:0]  s_fwd_i,
    input  logic [31:0] s_exma_val_i,
    input  logic [31:0] s_mawb_val_i,
    input  logic        s_ack_i,
    output logic        s_busy_o,
    output logic        s_valid_o,
    output logic [31:0] s_result_o
);

    div_state    state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        rem_sel_q, rem_sel_d;
    logic [31:0] result_q, result_d;

    logic [31:0] op1, op2;
    logic [31:0] abs1, abs2;
    logic        is_signed, is_rem;
    logic        sign1, sign2;
    logic        div_zero, overflow;
    logic [31:0] step_rem, step_quo;
    logic [31:0] quo_fin, rem_fin;

    div_step u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Operand resolution: MA forwarding wins over WB.
    always_comb begin
        op1 = s_fwd_i[0] ? s_exma_val_i : (s_fwd_i[2] ? s_mawb_val_i : s_operand1_i);
        op2 = s_fwd_i[1] ? s_exma_val_i : (s_fwd_i[3] ? s_mawb_val_i : s_operand2_i);

        is_signed = (s_f_i == DIV_F_DIV) || (s_f_i == DIV_F_REM);
        is_rem    = (s_f_i == DIV_F_REM) || (s_f_i == DIV_F_REMU);

        sign1 = is_signed & op1[31];
        sign2 = is_signed & op2[31];
        abs1  = sign1 ? neg32(op1) : op1;
        abs2  = sign2 ? neg32(op2) : op2;

        div_zero = (op2 == 32'd0);
        overflow = is_signed && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

        quo_fin = neg_quo_q ? neg32(step_quo) : step_quo;
        rem_fin = neg_rem_q ? neg32(step_rem) : step_rem;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_sel_d = rem_sel_q;
        result_d  = result_q;
        s_busy_o  = 1'b0;
        s_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                s_busy_o = s_start_i;
                if (s_start_i && !s_flush_i) begin
                    rem_d     = 32'd0;
                    quo_d     = abs1;
                    dvs_d     = abs2;
                    neg_quo_d = (sign1 ^ sign2) & ~div_zero;
                    neg_rem_d = sign1;
                    rem_sel_d = is_rem;
                    cnt_d     = 5'd31;
                    if (FAST_SPECIAL && (div_zero || overflow)) begin
                        if (div_zero) begin
                            result_d = is_rem ? op1 : 32'hFFFF_FFFF;
                        end else begin
                            result_d = is_rem ? 32'd0 : 32'h8000_0000;
                        end
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                s_busy_o = 1'b1;
                rem_d    = step_rem;
                quo_d    = step_quo;
                cnt_d    = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    result_d = rem_sel_q ? rem_fin : quo_fin;
                    state_d  = DONE;
                end
            end
            DONE: begin
                s_valid_o = 1'b1;
                s_busy_o  = ~s_ack_i;
                if (s_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (s_flush_i) begin
            state_d   = IDLE;
            s_busy_o  = 1'b0;
            s_valid_o = 1'b0;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_sel_q <= rem_sel_d;
            result_q  <= result_d;
        end
    end

    assign s_result_o = result_q;

endmodule

// File: tb/tb_ex_divider.sv
// Directed bench for ex_divider: fast-special and full-iteration instances side by side.
module tb_ex_divider;
    import p_hardisc::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        ack = 1'b1;
    logic [1:0]  f = 2'b00;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic [3:0]  fwd = 4'd0;
    logic [31:0] exma = 32'd0;
    logic [31:0] mawb = 32'd0;

    logic        busy_f, valid_f, busy_s, valid_s;
    logic [31:0] res_f, res_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_divider #(.FAST_SPECIAL(1'b1)) dut_fast (
        .s_clk_i      (clk),
        .s_resetn_i   (resetn),
        .s_start_i    (start),
        .s_flush_i    (flush),
        .s_f_i        (f),
        .s_operand1_i (opa),
        .s_operand2_i (opb),
        .s_fwd_i      (fwd),
        .s_exma_val_i (exma),
        .s_mawb_val_i (mawb),
        .s_ack_i      (ack),
        .s_busy_o     (busy_f),
        .s_valid_o    (valid_f),
        .s_result_o   (res_f)
    );

    ex_divider #(.FAST_SPECIAL(1'b0)) dut_slow (
        .s_clk_i      (clk),
        .s_resetn_i   (resetn),
        .s_start_i    (start),
        .s_flush_i    (flush),
        .s_f_i        (f),
        .s_operand1_i (opa),
        .s_operand2_i (opb),
        .s_fwd_i      (fwd),
        .s_exma_val_i (exma),
        .s_mawb_val_i (mawb),
        .s_ack_i      (ack),
        .s_busy_o     (busy_s),
        .s_valid_o    (valid_s),
        .s_result_o   (res_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // One operation with ack held high; records first valid cycle and busy cycle count.
    task automatic run_op(input string tag, input logic [1:0] fo, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] fw, input logic [31:0] exp,
                          input int lat_fast);
        int          cyc_f = -1;
        int          cyc_s = -1;
        int          bsy_f = 0;
        int          bsy_s = 0;
        logic [31:0] r_f = 32'd0;
        logic [31:0] r_s = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b1;
        f     = fo;
        opa   = a;
        opb   = b;
        fwd   = fw;
        ack   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy_f) bsy_f++;
            if (busy_s) bsy_s++;
            if (valid_f && cyc_f < 0) begin
                cyc_f = c;
                r_f   = res_f;
            end
            if (valid_s && cyc_s < 0) begin
                cyc_s = c;
                r_s   = res_s;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check({tag, " fast result"}, r_f, exp);
        check({tag, " fast latency"}, cyc_f, lat_fast);
        check({tag, " fast busy cycles"}, bsy_f, lat_fast);
        check({tag, " slow result"}, r_s, exp);
        check({tag, " slow latency"}, cyc_s, 33);
        check({tag, " slow busy cycles"}, bsy_s, 33);
    endtask

    initial begin
        int          first_v;
        logic [31:0] first_r;

        #2 resetn = 1'b0;
        #1;
        check("reset busy", {31'd0, busy_s}, 32'd0);
        check("reset valid", {31'd0, valid_s}, 32'd0);
        check("reset result", res_s, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        run_op("divu 100/7", DIV_F_DIVU, 32'd100, 32'd7, 4'b0000, 32'd14, 33);
        run_op("remu 100/7", DIV_F_REMU, 32'd100, 32'd7, 4'b0000, 32'd2, 33);
        run_op("div -100/7", DIV_F_DIV, 32'hFFFF_FF9C, 32'd7, 4'b0000, 32'hFFFF_FFF2, 33);
        run_op("rem -100/7", DIV_F_REM, 32'hFFFF_FF9C, 32'd7, 4'b0000, 32'hFFFF_FFFE, 33);
        run_op("rem 100/-7", DIV_F_REM, 32'd100, 32'hFFFF_FFF9, 4'b0000, 32'd2, 33);
        run_op("div 7/-1", DIV_F_DIV, 32'd7, 32'hFFFF_FFFF, 4'b0000, 32'hFFFF_FFF9, 33);
        run_op("divu max/1", DIV_F_DIVU, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'hFFFF_FFFF, 33);
        run_op("div x/0", DIV_F_DIV, 32'h1234, 32'd0, 4'b0000, 32'hFFFF_FFFF, 1);
        run_op("rem x/0", DIV_F_REM, 32'h1234, 32'd0, 4'b0000, 32'h1234, 1);
        run_op("div ovf", DIV_F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, 32'h8000_0000, 1);
        run_op("rem ovf", DIV_F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1);
        run_op("divu no ovf", DIV_F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, 32'd0, 33);

        exma = 32'd50;
        mawb = 32'd3;
        run_op("fwd 0101", DIV_F_DIVU, 32'd1000, 32'd5, 4'b0101, 32'd10, 33);
        run_op("fwd 1000", DIV_F_DIVU, 32'd9, 32'd5, 4'b1000, 32'd3, 33);
        run_op("fwd 0100", DIV_F_REMU, 32'd1000, 32'd5, 4'b0100, 32'd3, 33);
        run_op("fwd 1111", DIV_F_DIVU, 32'd1000, 32'd5, 4'b1111, 32'd1, 33);
        fwd = 4'b0000;

        // Flush at cycle 10, restart at cycle 12 with 200/9.
        first_v = -1;
        first_r = 32'd0;
        @(posedge clk);
        #1;
        f   = DIV_F_DIVU;
        opa = 32'd100;
        opb = 32'd7;
        for (int c = 0; c < 50; c++) begin
            start = (c == 0) || (c == 12);
            flush = (c == 10);
            if (c == 12) begin
                opa = 32'd200;
                opb = 32'd9;
            end
            @(negedge clk);
            if (c == 10) begin
                check("flush cycle busy", {31'd0, busy_s}, 32'd0);
                check("flush cycle valid", {31'd0, valid_s}, 32'd0);
            end
            if (c == 11) check("after flush busy", {31'd0, busy_s}, 32'd0);
            if (valid_s && first_v < 0) begin
                first_v = c;
                first_r = res_s;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        flush = 1'b0;
        check("restart latency", first_v, 45);
        check("restart result", first_r, 32'd22);

        // Ack withheld for 5 DONE cycles; a start during BUSY must be ignored.
        @(posedge clk);
        #1;
        for (int c = 0; c < 41; c++) begin
            start = (c == 0) || (c == 5);
            ack   = (c >= 38);
            if (c == 0) begin
                opa = 32'd1000;
                opb = 32'd10;
            end
            if (c == 5) begin
                opa = 32'd7;
                opb = 32'd1;
            end
            @(negedge clk);
            if (c == 5) check("busy during start", {31'd0, busy_s}, 32'd1);
            if (c == 33 || c == 35 || c == 37) begin
                check("held valid", {31'd0, valid_s}, 32'd1);
                check("held result", res_s, 32'd100);
                check("held busy", {31'd0, busy_s}, 32'd1);
            end
            if (c == 38) begin
                check("ack cycle busy", {31'd0, busy_s}, 32'd0);
                check("ack cycle valid", {31'd0, valid_s}, 32'd1);
            end
            if (c == 39) begin
                check("post ack valid", {31'd0, valid_s}, 32'd0);
                check("post ack result", res_s, 32'd100);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        ack   = 1'b1;

        // Reset pulsed in the middle of BUSY.
        opa = 32'd500;
        opb = 32'd3;
        for (int c = 0; c < 10; c++) begin
            start = (c == 0);
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        resetn = 1'b0;
        #1;
        check("mid reset busy", {31'd0, busy_s}, 32'd0);
        check("mid reset valid", {31'd0, valid_s}, 32'd0);
        check("mid reset result", res_s, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        first_v = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (valid_s && first_v < 0) first_v = c;
        end
        check("no result after reset", first_v, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
